sobel_frame_ctrl: RTL

//  Frame-level sequencer between uart_rx and sobel_applier. Parses a 2-byte header
//  (width W, height H), streams exactly W*H pixel bytes into the Sobel datapath with
//  row/frame tags, then forwards (W-2)*(H-2) result bytes to uart_tx, one per tx slot.

---
 rtl/sobel_pkg.sv | 33 +++
 rtl/sobel_skid_buf.sv | 44 ++++
 rtl/sobel_frame_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame sequencer.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_H,
    CHECK,
    STREAM,
    DRAIN
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_DIM  = 3'd1,
    ERR_OVF  = 3'd2,
    ERR_UART = 3'd3,
    ERR_TMO  = 3'd4
  } err_e;

  localparam logic [7:0]  MIN_DIM = 8'd3;
  localparam int unsigned HDR_LEN = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       eol;
    logic       eof;
  } pix_t;

  function automatic logic dim_ok(input logic [7:0] d, input logic [7:0] max_d);
    return (d >= MIN_DIM) && (d <= max_d);
  endfunction

endpackage

// File: rtl/sobel_skid_buf.sv
// One-entry pixel buffer; a full entry may be replaced in the cycle it is drained.
module sobel_skid_buf
  import sobel_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  pix_t in_pix_i,
  output logic out_valid_o,
  output pix_t out_pix_o,
  input  logic out_ready_i
);

  logic full_q, full_d;
  pix_t pix_q, pix_d;

  assign in_ready_o  = !full_q || out_ready_i;
  assign out_valid_o = full_q;
  assign out_pix_o   = pix_q;

  always_comb begin
    full_d = full_q;
    pix_d  = pix_q;
    if (full_q && out_ready_i) full_d = 1'b0;
    if (in_valid_i && in_ready_o) begin
      full_d = 1'b1;
      pix_d  = in_pix_i;
    end
    if (flush_i) full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      pix_q  <= '0;
    end else begin
      full_q <= full_d;
      pix_q  <= pix_d;
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: header parse, tagged pixel streaming into the Sobel datapath,
// result forwarding to the UART transmitter, timeout and sticky error reporting.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned MAX_W       = 255,
  parameter int unsigned MAX_H       = 255,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [2:0] rx_status,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_eol,
  output logic       pix_eof,
  input  logic [7:0] res_data,
  input  logic       res_valid,
  output logic       res_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [7:0] frame_w,
  output logic [7:0] frame_h,
  output logic       busy,
  output logic [2:0] err
);

  state_e      state_q, state_d;
  err_e        err_q, err_d;
  logic [7:0]  w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
  logic [15:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, pix_total, res_total;
  logic [31:0] tmo_q, tmo_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rx_ok, rx_bad, tmo_hit, push, flush, skid_in_ready;
  logic        pix_fire, res_fire, last_col;
  pix_t        in_pix, out_pix;

  assign pix_total = {8'd0, w_q} * {8'd0, h_q};
  assign res_total = ({8'd0, w_q} - 16'd2) * ({8'd0, h_q} - 16'd2);
  assign rx_ok     = rx_valid && (rx_status == 3'd0);
  assign rx_bad    = rx_valid && (rx_status != 3'd0);
  assign tmo_hit   = (TIMEOUT_CYC != 0) && !rx_valid && (tmo_q == 32'(TIMEOUT_CYC - 1));
  assign last_col  = (col_q == w_q - 8'd1);
  assign in_pix    = '{data: rx_data, eol: last_col, eof: last_col && (row_q == h_q - 8'd1)};
  assign pix_fire  = pix_valid && pix_ready;
  assign res_ready = ((state_q == STREAM) || (state_q == DRAIN)) && !tx_busy && !tx_start_q;
  assign res_fire  = res_valid && res_ready;

  sobel_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .in_valid_i (push),
    .in_ready_o (skid_in_ready),
    .in_pix_i   (in_pix),
    .out_valid_o(pix_valid),
    .out_pix_o  (out_pix),
    .out_ready_i(pix_ready)
  );

  assign pix_data = out_pix.data;
  assign pix_eol  = out_pix.eol;
  assign pix_eof  = out_pix.eof;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign frame_w  = w_q;
  assign frame_h  = h_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    w_d        = w_q;
    h_d        = h_q;
    col_d      = col_q;
    row_d      = row_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    tmo_d      = '0;
    push       = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (res_fire) begin
      tx_data_d  = res_data;
      tx_start_d = 1'b1;
      out_cnt_d  = out_cnt_q + 16'd1;
    end
    case (state_q)
      IDLE: begin
        if (rx_ok) begin
          w_d     = rx_data;
          err_d   = ERR_NONE;
          state_d = HDR_H;
        end
      end
      HDR_H: begin
        tmo_d = rx_valid ? '0 : tmo_q + 32'd1;
        if (rx_ok) begin
          h_d     = rx_data;
          state_d = CHECK;
        end else if (tmo_hit) begin
          err_d   = ERR_TMO;
          state_d = IDLE;
        end
      end
      CHECK: begin
        col_d     = '0;
        row_d     = '0;
        in_cnt_d  = '0;
        out_cnt_d = '0;
        if (rx_ok) err_d = ERR_OVF;
        if (dim_ok(w_q, 8'(MAX_W)) && dim_ok(h_q, 8'(MAX_H))) begin
          state_d = STREAM;
        end else begin
          err_d   = ERR_DIM;
          state_d = IDLE;
        end
      end
      STREAM: begin
        tmo_d = rx_valid ? '0 : tmo_q + 32'd1;
        if (rx_ok) begin
          // Bytes beyond W*H or hitting a stalled full buffer are dropped, counts untouched.
          if ((in_cnt_q != pix_total) && skid_in_ready) begin
            push     = 1'b1;
            in_cnt_d = in_cnt_q + 16'd1;
            if (last_col) begin
              col_d = '0;
              row_d = row_q + 8'd1;
            end else begin
              col_d = col_q + 8'd1;
            end
          end else begin
            err_d = ERR_OVF;
          end
        end
        if (pix_fire && pix_eof) begin
          state_d = DRAIN;
        end else if (tmo_hit) begin
          err_d   = ERR_TMO;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (rx_ok) err_d = ERR_OVF;
        if (out_cnt_q >= res_total) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rx_bad) begin
      err_d   = ERR_UART;
      state_d = IDLE;
    end
    flush = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      err_q      <= ERR_NONE;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      tmo_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      w_q        <= w_d;
      h_q        <= h_d;
      col_q      <= col_d;
      row_q      <= row_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      tmo_q      <= tmo_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule
